mult_div_unit: RTL and testbench

- Iterative radix-2 multiply/divide engine. Produces the HI/LO results and one-cycle write strobes that load the CPU's HI/LO register file.
- Sits between the execute stage and the HI/LO registers. The pipeline stalls on busy.
- Handles MULT, MULTU, DIV and DIVU at a fixed 34-cycle latency.

---
 rtl/mult_div_unit.sv | 94 +++++++++
 tb/tb_mult_div_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 MULT/MULTU/DIV/DIVU engine feeding HI/LO; ports clk, reset_n, clk_enable, start, op, src_a, src_b -> busy, HI_input, LO_input, HI/LO_write_enable; optional MULT_DIV_FAST_ZERO_EN skips iterations for zero operands
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER = WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] HI_input,
  output logic [WIDTH-1:0] LO_input,
  output logic             HI_write_enable,
  output logic             LO_write_enable
);
  localparam int CW = $clog2(ITER + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi_r, lo_r, m_r, a_mag, b_mag, sub;
  logic is_div, neg_q, neg_r, ge;
  logic [WIDTH:0] sum, shifted;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    a_mag = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;
    sum = {1'b0, hi_r} + {1'b0, lo_r[0] ? m_r : '0};
    shifted = {hi_r, lo_r[WIDTH-1]};
    ge = shifted >= {1'b0, m_r};
    sub = shifted[WIDTH-1:0] - m_r;
    prod = neg_q ? -{hi_r, lo_r} : {hi_r, lo_r};
  end
  assign busy = state != IDLE;
  assign HI_write_enable = state == DONE;
  assign LO_write_enable = state == DONE;
  // Multiply: m_r = |a|, lo_r = |b| shifting out, {hi_r,lo_r} accumulates the product.
  // Divide: m_r = |b|, lo_r = |a| shifting out / quotient shifting in, hi_r = remainder.
  // RUN spends ITER+1 edges: ITER iterations plus one final settle edge before FIX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      hi_r <= '0;
      lo_r <= '0;
      m_r <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      HI_input <= '0;
      LO_input <= '0;
    end else if (clk_enable) begin
      case (state)
        IDLE: if (start) begin
          is_div <= op[1];
          neg_q <= op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          neg_r <= op[0] & op[1] & src_a[WIDTH-1];
          m_r <= op[1] ? b_mag : a_mag;
          lo_r <= op[1] ? a_mag : b_mag;
          hi_r <= '0;
          cnt <= '0;
          state <= RUN;
`ifdef MULT_DIV_FAST_ZERO_EN
          if (op[1] ? src_b == '0 : (src_a == '0 || src_b == '0)) begin
            HI_input <= op[1] ? src_a : '0;
            LO_input <= op[1] ? ((op[0] && src_a[WIDTH-1]) ? WIDTH'(1) : '1) : '0;
            state <= DONE;
          end
`endif
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER))
            state <= FIX;
          else if (is_div) begin
            hi_r <= ge ? sub : shifted[WIDTH-1:0];
            lo_r <= {lo_r[WIDTH-2:0], ge};
          end else begin
            hi_r <= sum[WIDTH:1];
            lo_r <= {sum[0], lo_r[WIDTH-1:1]};
          end
        end
        FIX: begin
          HI_input <= is_div ? (neg_r ? -hi_r : hi_r) : prod[2*WIDTH-1:WIDTH];
          LO_input <= is_div ? (neg_q ? -lo_r : lo_r) : prod[WIDTH-1:0];
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  logic clk = 0, reset_n = 0, clk_enable = 1, start = 0;
  logic [1:0] op = 0;
  logic [31:0] src_a = 0, src_b = 0;
  logic busy, HI_write_enable, LO_write_enable;
  logic [31:0] HI_input, LO_input;
  int n_cmp = 0, n_bad = 0;
  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .HI_input(HI_input), .LO_input(LO_input),
    .HI_write_enable(HI_write_enable), .LO_write_enable(LO_write_enable)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int q, r;
    case (o)
      2'd0: return {32'd0, a} * {32'd0, b};
      2'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'd2: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) return {a, a[31] ? 32'd1 : 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
    endcase
  endfunction
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_DIV_FAST_ZERO_EN
    if (o[1] ? b == 0 : (a == 0 || b == 0)) return 0;
`endif
    return 34;
  endfunction
  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction
  // Called at a negedge; returns at the negedge of the cycle after the strobe.
  // lat = edges after the accepting edge until the strobe cycle (34 for a full op).
  // mode 1 pulses start at k=5 and k=20, mode 2 drops clk_enable for 10 edges.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int mode,
                       output int lat, output logic [31:0] hi, output logic [31:0] lo,
                       output bit busy_ok, output bit after_ok);
    int k;
    op = o; src_a = a; src_b = b; start = 1;
    @(negedge clk);
    start = 0;
    k = 0;
    busy_ok = 1;
    while (!HI_write_enable && k < 200) begin
      busy_ok &= busy;
      start = (mode == 1 && (k == 5 || k == 20));
      if (start) begin op = 2'($urandom); src_a = $urandom; src_b = $urandom | 1; end
      clk_enable = !(mode == 2 && k >= 10 && k < 20);
      @(negedge clk);
      k++;
    end
    start = 0;
    clk_enable = 1;
    busy_ok &= busy & LO_write_enable;
    lat = k;
    hi = HI_input;
    lo = LO_input;
    @(negedge clk);
    after_ok = !HI_write_enable && !LO_write_enable && !busy;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, HI_write_enable, LO_write_enable} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000", {busy, HI_write_enable, LO_write_enable});
    end
    n_cmp++;
    if ({HI_input, LO_input} !== 64'd0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {HI_input, LO_input});
    end
    reset_n = 1;
    @(negedge clk);
  endtask
  task automatic test_directed();
    logic [1:0] ops[8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};
    logic [31:0] as[8] = '{32'hFFFF_FFFF, -32'd3, -32'd7, 32'd100, 32'h8000_0000, 32'd5, -32'd9, 32'd9};
    logic [31:0] bs[8] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    logic [63:0] fixed[4] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFD, 64'h2_0000_000E};
    for (int i = 0; i < 8; i++) begin
      int lat;
      logic [31:0] hi, lo;
      bit bok, aok;
      logic [63:0] want;
      do_op(ops[i], as[i], bs[i], 0, lat, hi, lo, bok, aok);
      want = i < 4 ? fixed[i] : model(ops[i], as[i], bs[i]);
      n_cmp++;
      if ({hi, lo} !== want) begin
        n_bad++; $display("FAIL dir%0d_result: got %h want %h", i, {hi, lo}, want);
      end
      n_cmp++;
      if (lat !== exp_lat(ops[i], as[i], bs[i])) begin
        n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat(ops[i], as[i], bs[i]));
      end
      n_cmp++;
      if (!(bok && aok)) begin
        n_bad++; $display("FAIL dir%0d_strobe_busy: busy_ok %0d single_strobe %0d want 1 1", i, bok, aok);
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int lat;
      logic [31:0] hi, lo, a, b;
      logic [1:0] o;
      bit bok, aok;
      o = 2'($urandom);
      a = rnd_val();
      b = rnd_val();
      do_op(o, a, b, 0, lat, hi, lo, bok, aok);
      n_cmp++;
      if ({hi, lo} !== model(o, a, b) || lat !== exp_lat(o, a, b) || !bok || !aok) begin
        n_bad++;
        $display("FAIL rnd%0d op%0d a=%h b=%h: got %h lat %0d ok %0d%0d want %h lat %0d ok 11",
                 i, o, a, b, {hi, lo}, lat, bok, aok, model(o, a, b), exp_lat(o, a, b));
      end
    end
  endtask
  task automatic test_ignore_start();
    int lat, extra;
    logic [31:0] hi, lo;
    bit bok, aok;
    do_op(2'd1, 32'd123456, -32'd789, 1, lat, hi, lo, bok, aok);
    extra = 0;
    repeat (45) begin
      @(negedge clk);
      extra += HI_write_enable;
    end
    n_cmp++;
    if ({hi, lo} !== model(2'd1, 32'd123456, -32'd789) || lat !== 34) begin
      n_bad++; $display("FAIL ignore_start_result: got %h lat %0d want %h lat 34", {hi, lo}, lat, model(2'd1, 32'd123456, -32'd789));
    end
    n_cmp++;
    if (extra !== 0 || !aok) begin
      n_bad++; $display("FAIL ignore_start_strobes: extra strobes %0d single %0d want 0 1", extra, aok);
    end
  endtask
  task automatic test_clk_enable();
    int lat;
    logic [31:0] hi, lo;
    bit bok, aok;
    do_op(2'd2, 32'd1000, 32'd33, 2, lat, hi, lo, bok, aok);
    n_cmp++;
    if (lat !== 44) begin
      n_bad++; $display("FAIL clk_enable_latency: got %0d want 44", lat);
    end
    n_cmp++;
    if ({hi, lo} !== {32'd10, 32'd30} || !bok || !aok) begin
      n_bad++; $display("FAIL clk_enable_result: got %h ok %0d%0d want %h ok 11", {hi, lo}, bok, aok, {32'd10, 32'd30});
    end
  endtask
  task automatic test_reset_mid();
    int lat, strobes;
    logic [31:0] hi, lo;
    bit bok, aok;
    op = 2'd1; src_a = 32'd77; src_b = -32'd5; start = 1;
    @(negedge clk);
    start = 0;
    repeat (15) @(negedge clk);
    #2 reset_n = 0;
    #1;
    n_cmp++;
    if ({busy, HI_write_enable, LO_write_enable} !== 3'b000 || {HI_input, LO_input} !== 64'd0) begin
      n_bad++; $display("FAIL reset_mid_clear: ctrl %b data %h want 000 0", {busy, HI_write_enable, LO_write_enable}, {HI_input, LO_input});
    end
    @(negedge clk);
    reset_n = 1;
    strobes = 0;
    repeat (50) begin
      @(negedge clk);
      strobes += HI_write_enable + LO_write_enable + busy;
    end
    n_cmp++;
    if (strobes !== 0) begin
      n_bad++; $display("FAIL reset_mid_no_strobe: got %0d activity cycles want 0", strobes);
    end
    do_op(2'd0, 32'd6, 32'd7, 0, lat, hi, lo, bok, aok);
    n_cmp++;
    if ({hi, lo} !== 64'd42 || lat !== 34) begin
      n_bad++; $display("FAIL reset_mid_after: got %h lat %0d want 42 lat 34", {hi, lo}, lat);
    end
  endtask
  task automatic test_back_to_back();
    int lat1, lat2;
    logic [31:0] h1, l1, h2, l2;
    bit b1, a1, b2, a2;
    do_op(2'd3, -32'd1000, 32'd7, 0, lat1, h1, l1, b1, a1);
    do_op(2'd0, 32'hDEAD_BEEF, 32'h1234_5678, 0, lat2, h2, l2, b2, a2);
    n_cmp++;
    if ({h1, l1} !== model(2'd3, -32'd1000, 32'd7) || {h2, l2} !== model(2'd0, 32'hDEAD_BEEF, 32'h1234_5678)) begin
      n_bad++; $display("FAIL back_to_back_result: got %h %h want %h %h", {h1, l1}, {h2, l2},
                        model(2'd3, -32'd1000, 32'd7), model(2'd0, 32'hDEAD_BEEF, 32'h1234_5678));
    end
    n_cmp++;
    if (lat2 !== 34 || !b2 || !a2) begin
      n_bad++; $display("FAIL back_to_back_timing: got lat %0d ok %0d%0d want 34 ok 11", lat2, b2, a2);
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_clk_enable();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
